// File: rtl/fp_mul_wb_if.sv
// Handshake bundle between the FP multiplier, its writeback stage and the
// register-file consumer: upstream push channel plus downstream pop channel.
interface fp_mul_wb_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_p;
  logic [4:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_rd;
  logic [4:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_p, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_p, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_flags
  );
endinterface

// File: rtl/fp_mul_wb.sv
// Single-precision multiplier writeback: NaN canonicalization, IEEE flag
// derivation, 2-entry result FIFO and sticky fflags accumulator.
module fp_mul_wb #(
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input  logic             clk,
  input  logic             rst,
  fp_mul_wb_if.slave       bus,
  input  logic             fflags_clr,
  output logic [4:0]       fflags
);
  localparam int W = NEXP + NSIG + 1;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  function automatic logic exp_ones(input logic [W-1:0] x);
    return &x[W-2:NSIG];
  endfunction

  function automatic logic exp_zero(input logic [W-1:0] x);
    return ~|x[W-2:NSIG];
  endfunction

  function automatic logic frac_zero(input logic [W-1:0] x);
    return ~|x[NSIG-1:0];
  endfunction

  function automatic logic is_inf(input logic [W-1:0] x);
    return exp_ones(x) & frac_zero(x);
  endfunction

  function automatic logic is_nan(input logic [W-1:0] x);
    return exp_ones(x) & ~frac_zero(x);
  endfunction

  function automatic logic is_snan(input logic [W-1:0] x);
    return is_nan(x) & ~x[NSIG-1];
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    return exp_zero(x) & frac_zero(x);
  endfunction

  function automatic logic is_finnz(input logic [W-1:0] x);
    return ~exp_ones(x) & ~is_zero(x);
  endfunction

  // NX is conservative: without rounding bits, any OF/UF is assumed inexact.
  function automatic logic [4:0] calc_flags(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] p);
    logic nv, of, uf;
    nv = is_snan(a) | is_snan(b) | (is_inf(a) & is_zero(b)) | (is_zero(a) & is_inf(b));
    of = is_inf(p) & ~(is_inf(a) | is_nan(a) | is_inf(b) | is_nan(b));
    uf = exp_zero(p) & is_finnz(a) & is_finnz(b);
    return {nv, 1'b0, of, uf, of | uf};
  endfunction

  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic [W-1:0] res_q [0:1];
  logic [W-1:0] res_d [0:1];
  logic [4:0]   rd_q  [0:1];
  logic [4:0]   rd_d  [0:1];
  logic [4:0]   flg_q [0:1];
  logic [4:0]   flg_d [0:1];
  logic [4:0]   fflags_q, fflags_d;
  logic         push_s, pop_s;

  assign bus.in_ready   = ~rst & (count_q != 2'd2);
  assign bus.out_valid  = (count_q != 2'd0);
  assign bus.out_result = res_q[rd_ptr_q];
  assign bus.out_rd     = rd_q[rd_ptr_q];
  assign bus.out_flags  = flg_q[rd_ptr_q];
  assign fflags         = fflags_q;

  assign push_s = bus.in_valid & bus.in_ready;
  assign pop_s  = bus.out_valid & bus.out_ready & ~rst;

  // Next-state for FIFO storage, pointers, occupancy and sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fflags_d = fflags_q;
    for (int i = 0; i < 2; i++) begin
      res_d[i] = res_q[i];
      rd_d[i]  = rd_q[i];
      flg_d[i] = flg_q[i];
    end

    if (push_s) begin
      res_d[wr_ptr_q] = is_nan(bus.in_p) ? CANON_NAN : bus.in_p;
      rd_d[wr_ptr_q]  = bus.in_rd;
      flg_d[wr_ptr_q] = calc_flags(bus.in_a, bus.in_b, bus.in_p);
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // A pop in the clear cycle still lands in the accumulator.
    fflags_d = (fflags_clr ? 5'd0 : fflags_q) | (pop_s ? bus.out_flags : 5'd0);
  end

  // State register with synchronous reset that empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      fflags_q <= 5'd0;
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= '0;
        rd_q[i]  <= 5'd0;
        flg_q[i] <= 5'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= res_d[i];
        rd_q[i]  <= rd_d[i];
        flg_q[i] <= flg_d[i];
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_wb.sv
// Directed self-checking bench for fp_mul_wb; inputs change and outputs are
// sampled on the falling edge, state advances on the rising edge.
module tb_fp_mul_wb;
  logic       clk;
  logic       rst;
  logic       fflags_clr;
  logic [4:0] fflags;
  int         n_checks;
  int         n_errors;

  fp_mul_wb_if #(.W(32)) bus ();

  fp_mul_wb #(.NEXP(8), .NSIG(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fflags_clr (fflags_clr),
    .fflags     (fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one push for a single rising edge, return at the next falling edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_p     = p;
    bus.in_rd    = rd;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_flags();
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    fflags_clr    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.in_p      = 32'h0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("rst_result",    bus.out_result, 32'h0);
    chk("rst_rd",        {27'd0, bus.out_rd}, 32'd0);
    chk("rst_flags",     {27'd0, bus.out_flags}, 32'd0);
    chk("rst_fflags",    {27'd0, fflags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Normal product, one-cycle latency
    bus.out_ready = 1'b1;
    send(32'h40000000, 32'h40400000, 32'h40C00000, 5'd3);
    chk("norm_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("norm_result", bus.out_result, 32'h40C00000);
    chk("norm_rd",     {27'd0, bus.out_rd}, 32'd3);
    chk("norm_flags",  {27'd0, bus.out_flags}, 32'd0);
    @(negedge clk);
    chk("norm_fflags", {27'd0, fflags}, 32'd0);
    chk("norm_drained", {31'd0, bus.out_valid}, 32'd0);

    // Negative product keeps its sign; inf product from inf operand is not OF
    send(32'hC0000000, 32'h40400000, 32'hC0C00000, 5'd4);
    chk("neg_result", bus.out_result, 32'hC0C00000);
    chk("neg_flags",  {27'd0, bus.out_flags}, 32'd0);
    send(32'h7F800000, 32'h40000000, 32'h7F800000, 5'd5);
    chk("infop_result", bus.out_result, 32'h7F800000);
    chk("infop_flags",  {27'd0, bus.out_flags}, 32'd0);
    @(negedge clk);

    // SNaN operand
    send(32'h7F800001, 32'h3F800000, 32'h7F800001, 5'd6);
    chk("snan_result", bus.out_result, 32'h7FC00000);
    chk("snan_flags",  {27'd0, bus.out_flags}, 32'h10);
    @(negedge clk);
    chk("snan_fflags", {27'd0, fflags}, 32'h10);

    // Inf x zero
    send(32'hFF800000, 32'h00000000, 32'hFF80002A, 5'd7);
    chk("infz_result", bus.out_result, 32'h7FC00000);
    chk("infz_flags",  {27'd0, bus.out_flags}, 32'h10);
    @(negedge clk);
    clear_flags();
    chk("clr0_fflags", {27'd0, fflags}, 32'd0);

    // Overflow, clear, underflow
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 5'd8);
    chk("of_result", bus.out_result, 32'h7F800000);
    chk("of_flags",  {27'd0, bus.out_flags}, 32'h05);
    @(negedge clk);
    chk("of_fflags", {27'd0, fflags}, 32'h05);
    clear_flags();
    chk("clr1_fflags", {27'd0, fflags}, 32'd0);
    send(32'h00800000, 32'h00800000, 32'h00000000, 5'd9);
    chk("uf_result", bus.out_result, 32'h0);
    chk("uf_flags",  {27'd0, bus.out_flags}, 32'h03);
    @(negedge clk);
    chk("uf_fflags", {27'd0, fflags}, 32'h03);

    // Clear coinciding with a pop keeps only the popped flags
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 5'd10);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    chk("clrpop_fflags", {27'd0, fflags}, 32'h05);
    clear_flags();

    // Back-pressure: three pushes, only two accepted until the consumer drains
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'h3F800000;
    bus.in_b      = 32'h3F800000;
    bus.in_p      = 32'h3F800000;
    bus.in_rd     = 5'd1;
    @(negedge clk);
    chk("bp_ready_after1", {31'd0, bus.in_ready}, 32'd1);
    bus.in_rd = 5'd2;
    @(negedge clk);
    chk("bp_ready_after2", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head1",        {27'd0, bus.out_rd}, 32'd1);
    bus.in_rd = 5'd3;
    @(negedge clk);
    chk("bp_held_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head_stable", {27'd0, bus.out_rd}, 32'd1);
    chk("bp_valid",      {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head2",     {27'd0, bus.out_rd}, 32'd2);
    chk("bp_ready_ret", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_head3",  {27'd0, bus.out_rd}, 32'd3);
    chk("bp_valid3", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-operation discards buffered entries and their flags
    bus.out_ready = 1'b0;
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 5'd11);
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 5'd12);
    chk("mid_full", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_fflags", {27'd0, fflags}, 32'd0);
    chk("mid_rst_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("mid_rst_flags",  {27'd0, bus.out_flags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("mid_post_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("mid_post_fflags", {27'd0, fflags}, 32'd0);
    send(32'h40000000, 32'h40400000, 32'h40C00000, 5'd13);
    chk("mid_push_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("mid_push_rd",    {27'd0, bus.out_rd}, 32'd13);
    chk("mid_push_res",   bus.out_result, 32'h40C00000);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
